// File: rtl/rational_eval_seq_if.sv
// Sample/result handshake bundle for rational_eval_seq: z sample and root counts in,
// numerator/denominator products and overflow flag out.
interface rational_eval_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_ZEROS  = 8,
  parameter int MAX_POLES  = 8
);
  localparam int ZW = $clog2(MAX_ZEROS + 1);
  localparam int PW = $clog2(MAX_POLES + 1);

  logic                         in_valid;
  logic                         in_ready;
  logic        [ZW-1:0]         n_zeros;
  logic        [PW-1:0]         n_poles;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic signed [DATA_WIDTH-1:0] y_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] num_re;
  logic signed [DATA_WIDTH-1:0] num_im;
  logic signed [DATA_WIDTH-1:0] den_re;
  logic signed [DATA_WIDTH-1:0] den_im;
  logic                         out_ovf;

  modport master (
    output in_valid, n_zeros, n_poles, x_in, y_in, out_ready,
    input  in_ready, out_valid, num_re, num_im, den_re, den_im, out_ovf
  );

  modport slave (
    input  in_valid, n_zeros, n_poles, x_in, y_in, out_ready,
    output in_ready, out_valid, num_re, num_im, den_re, den_im, out_ovf
  );
endinterface

// File: rtl/rational_eval_seq.sv
// Sequential evaluator of N(z) = prod(z - zero_k) and D(z) = prod(z - pole_k) using a
// single time-shared saturating fixed-point complex multiplier.
module rational_eval_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int MAX_ZEROS  = 8,
  parameter int MAX_POLES  = 8,
  localparam int ZW   = $clog2(MAX_ZEROS + 1),
  localparam int PW   = $clog2(MAX_POLES + 1),
  localparam int MAXR = (MAX_ZEROS > MAX_POLES) ? MAX_ZEROS : MAX_POLES,
  localparam int IW   = (MAXR > 1) ? $clog2(MAXR) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic                         cfg_sel,
  input  logic        [IW-1:0]         cfg_idx,
  input  logic signed [DATA_WIDTH-1:0] cfg_re,
  input  logic signed [DATA_WIDTH-1:0] cfg_im,
  rational_eval_seq_if.slave           bus
);
  localparam int DW   = DATA_WIDTH;
  localparam int WIDE = 2 * DW + 1;
  localparam logic signed [DW-1:0]   SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]   ONE  = DW'(1 << FRAC_BITS);
  localparam logic signed [WIDE-1:0] RND  = WIDE'(1) << (FRAC_BITS - 1);
  localparam logic signed [WIDE-1:0] HI   = WIDE'(SMAX);
  localparam logic signed [WIDE-1:0] LO   = WIDE'(SMIN);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t state, state_d;

  logic signed [DW-1:0] zero_re [MAX_ZEROS];
  logic signed [DW-1:0] zero_im [MAX_ZEROS];
  logic signed [DW-1:0] pole_re [MAX_POLES];
  logic signed [DW-1:0] pole_im [MAX_POLES];

  logic signed [DW-1:0] z_re, z_im;
  logic signed [DW-1:0] num_acc_re, num_acc_im, den_acc_re, den_acc_im;
  logic signed [DW-1:0] num_q_re, num_q_im, den_q_re, den_q_im;
  logic                 ovf, ovf_q;
  logic        [ZW-1:0] nz;
  logic        [PW-1:0] np;
  logic        [IW-1:0] k;
  logic                 phase_den;

  // Old value of a root overwritten in the accept cycle, so that evaluation sees the pre-write file.
  logic                 sh_valid, sh_sel;
  logic        [IW-1:0] sh_idx;
  logic signed [DW-1:0] sh_re, sh_im;

  function automatic logic [DW:0] sub_sat(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    logic signed [DW:0] d;
    d = {a[DW-1], a} - {b[DW-1], b};
    if (d[DW] != d[DW-1]) return {1'b1, (d[DW] ? SMIN : SMAX)};
    return {1'b0, d[DW-1:0]};
  endfunction

  function automatic logic [DW:0] rnd_sat(input logic signed [WIDE-1:0] v);
    logic signed [WIDE-1:0] r;
    r = (v + RND) >>> FRAC_BITS;
    if (r > HI) return {1'b1, SMAX};
    if (r < LO) return {1'b1, SMIN};
    return {1'b0, r[DW-1:0]};
  endfunction

  logic                 in_ready, accept, wr_ok, last;
  logic        [ZW-1:0] nz_c;
  logic        [PW-1:0] np_c;
  logic signed [DW-1:0] root_re, root_im, old_re, old_im;
  logic signed [DW-1:0] d_re, d_im, a_re, a_im, p_re, p_im;
  logic                 d_re_ovf, d_im_ovf, p_re_ovf, p_im_ovf, step_ovf;
  logic signed [2*DW-1:0] ac, bd, ad, bc;

  assign in_ready = (state == IDLE) && rst_n;
  assign accept   = bus.in_valid && in_ready;
  assign nz_c     = (int'(bus.n_zeros) > MAX_ZEROS) ? ZW'(MAX_ZEROS) : bus.n_zeros;
  assign np_c     = (int'(bus.n_poles) > MAX_POLES) ? PW'(MAX_POLES) : bus.n_poles;
  assign wr_ok    = (state == IDLE) && cfg_we &&
                    (int'(cfg_idx) < (cfg_sel ? MAX_POLES : MAX_ZEROS));
  assign last     = int'(k) == ((phase_den ? int'(np) : int'(nz)) - 1);

  always_comb begin
    old_re = '0;
    old_im = '0;
    if (wr_ok) begin
      old_re = cfg_sel ? pole_re[cfg_idx] : zero_re[cfg_idx];
      old_im = cfg_sel ? pole_im[cfg_idx] : zero_im[cfg_idx];
    end
  end

  always_comb begin
    root_re = phase_den ? pole_re[k] : zero_re[k];
    root_im = phase_den ? pole_im[k] : zero_im[k];
    if (sh_valid && (sh_sel == phase_den) && (sh_idx == k)) begin
      root_re = sh_re;
      root_im = sh_im;
    end
    {d_re_ovf, d_re} = sub_sat(z_re, root_re);
    {d_im_ovf, d_im} = sub_sat(z_im, root_im);
    a_re = phase_den ? den_acc_re : num_acc_re;
    a_im = phase_den ? den_acc_im : num_acc_im;
    ac = (2*DW)'(a_re) * (2*DW)'(d_re);
    bd = (2*DW)'(a_im) * (2*DW)'(d_im);
    ad = (2*DW)'(a_re) * (2*DW)'(d_im);
    bc = (2*DW)'(a_im) * (2*DW)'(d_re);
    {p_re_ovf, p_re} = rnd_sat(WIDE'(ac) - WIDE'(bd));
    {p_im_ovf, p_im} = rnd_sat(WIDE'(ad) + WIDE'(bc));
    step_ovf = d_re_ovf | d_im_ovf | p_re_ovf | p_im_ovf;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = (nz_c == '0 && np_c == '0) ? DONE : EVAL;
      EVAL:    if (last && (phase_den || np == '0)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_ZEROS; i++) begin
        zero_re[i] <= '0;
        zero_im[i] <= '0;
      end
      for (int unsigned i = 0; i < MAX_POLES; i++) begin
        pole_re[i] <= '0;
        pole_im[i] <= '0;
      end
      z_re <= '0; z_im <= '0;
      num_acc_re <= '0; num_acc_im <= '0; den_acc_re <= '0; den_acc_im <= '0;
      num_q_re <= '0; num_q_im <= '0; den_q_re <= '0; den_q_im <= '0;
      ovf <= 1'b0; ovf_q <= 1'b0;
      nz <= '0; np <= '0; k <= '0; phase_den <= 1'b0;
      sh_valid <= 1'b0; sh_sel <= 1'b0; sh_idx <= '0; sh_re <= '0; sh_im <= '0;
    end else begin
      if (wr_ok) begin
        if (cfg_sel) begin
          pole_re[cfg_idx] <= cfg_re;
          pole_im[cfg_idx] <= cfg_im;
        end else begin
          zero_re[cfg_idx] <= cfg_re;
          zero_im[cfg_idx] <= cfg_im;
        end
      end
      if (accept) begin
        z_re <= bus.x_in; z_im <= bus.y_in;
        nz <= nz_c; np <= np_c; k <= '0;
        phase_den <= (nz_c == '0);
        num_acc_re <= ONE; num_acc_im <= '0;
        den_acc_re <= ONE; den_acc_im <= '0;
        ovf <= 1'b0;
        sh_valid <= wr_ok; sh_sel <= cfg_sel; sh_idx <= cfg_idx;
        sh_re <= old_re; sh_im <= old_im;
        if (state_d == DONE) begin
          num_q_re <= ONE; num_q_im <= '0;
          den_q_re <= ONE; den_q_im <= '0;
          ovf_q <= 1'b0;
        end
      end else if (state == EVAL) begin
        ovf <= ovf | step_ovf;
        if (phase_den) begin
          den_acc_re <= p_re; den_acc_im <= p_im;
        end else begin
          num_acc_re <= p_re; num_acc_im <= p_im;
        end
        if (state_d == DONE) begin
          num_q_re <= phase_den ? num_acc_re : p_re;
          num_q_im <= phase_den ? num_acc_im : p_im;
          den_q_re <= phase_den ? p_re : den_acc_re;
          den_q_im <= phase_den ? p_im : den_acc_im;
          ovf_q    <= ovf | step_ovf;
        end else if (last) begin
          phase_den <= 1'b1;
          k <= '0;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.num_re    = num_q_re;
  assign bus.num_im    = num_q_im;
  assign bus.den_re    = den_q_re;
  assign bus.den_im    = den_q_im;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_rational_eval_seq.sv
// Directed and randomized bench for rational_eval_seq against an integer reference model
// of the root products with saturating fixed-point arithmetic.
module tb_rational_eval_seq;
  localparam int DW = 16;
  localparam int FB = 12;
  localparam int MZ = 8;
  localparam int MP = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_we = 1'b0;
  logic                 cfg_sel = 1'b0;
  logic [2:0]           cfg_idx = '0;
  logic signed [DW-1:0] cfg_re = '0;
  logic signed [DW-1:0] cfg_im = '0;

  rational_eval_seq_if #(.DATA_WIDTH(DW), .MAX_ZEROS(MZ), .MAX_POLES(MP)) bus ();

  rational_eval_seq #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .MAX_ZEROS(MZ), .MAX_POLES(MP)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_re(cfg_re), .cfg_im(cfg_im), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_zr [MZ];
  int m_zi [MZ];
  int m_pr [MP];
  int m_pi [MP];
  int e_nr, e_ni, e_dr, e_di, e_lat;
  bit e_ovf;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input longint v, inout bit o);
    if (v > 32767)  begin o = 1'b1; return 32767;  end
    if (v < -32768) begin o = 1'b1; return -32768; end
    return int'(v);
  endfunction

  function automatic int rnd(input longint v, inout bit o);
    return sat((v + (64'sd1 <<< (FB - 1))) >>> FB, o);
  endfunction

  // Product of (z - root) over the first n roots, starting from 1.0.
  function automatic void cprod(input int zr, input int zi, input int n, input bit den,
                                output int pr, output int pi, inout bit o);
    int dr, di, tr;
    pr = 1 << FB;
    pi = 0;
    for (int k = 0; k < n; k++) begin
      dr = sat(longint'(zr) - (den ? m_pr[k] : m_zr[k]), o);
      di = sat(longint'(zi) - (den ? m_pi[k] : m_zi[k]), o);
      tr = rnd(longint'(pr) * dr - longint'(pi) * di, o);
      pi = rnd(longint'(pr) * di + longint'(pi) * dr, o);
      pr = tr;
    end
  endfunction

  function automatic void model(input int zr, input int zi, input int nz, input int np);
    int cz, cp;
    bit o;
    o  = 1'b0;
    cz = (nz > MZ) ? MZ : nz;
    cp = (np > MP) ? MP : np;
    cprod(zr, zi, cz, 1'b0, e_nr, e_ni, o);
    cprod(zr, zi, cp, 1'b1, e_dr, e_di, o);
    e_ovf = o;
    e_lat = cz + cp + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int idx, input int re, input int im);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = 3'(idx); cfg_re = DW'(re); cfg_im = DW'(im);
    tick();
    cfg_we = 1'b0;
    if (sel) begin m_pr[idx] = re; m_pi[idx] = im; end
    else     begin m_zr[idx] = re; m_zi[idx] = im; end
  endtask

  task automatic start(input int zr, input int zi, input int nz, input int np, input bit chk_ready);
    model(zr, zi, nz, np);
    bus.x_in = DW'(zr); bus.y_in = DW'(zi);
    bus.n_zeros = 4'(nz); bus.n_poles = 4'(np);
    if (chk_ready) check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_num_re"}, bus.num_re, e_nr);
    check({tag, "_num_im"}, bus.num_im, e_ni);
    check({tag, "_den_re"}, bus.den_re, e_dr);
    check({tag, "_den_im"}, bus.den_im, e_di);
    check({tag, "_ovf"}, bus.out_ovf, e_ovf);
  endtask

  task automatic finish_eval(input string tag);
    int cnt;
    tick();
    bus.in_valid = 1'b0;
    cfg_we = 1'b0;
    cnt = 1;
    while (!bus.out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    check({tag, "_latency"}, cnt, e_lat);
    check_outputs(tag);
    if (bus.out_ready) begin
      tick();
      check({tag, "_valid_drop"}, bus.out_valid, 0);
      check({tag, "_ready_back"}, bus.in_ready, 1);
    end
  endtask

  initial begin
    int hz_re, hz_im;
    bit seen;
    foreach (m_zr[i]) begin m_zr[i] = 0; m_zi[i] = 0; end
    foreach (m_pr[i]) begin m_pr[i] = 0; m_pi[i] = 0; end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.x_in = '0; bus.y_in = '0; bus.n_zeros = '0; bus.n_poles = '0;

    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_num_re", bus.num_re, 0);
    check("rst_den_re", bus.den_re, 0);
    check("rst_ovf", bus.out_ovf, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // 1: one zero, one pole
    wr(1'b0, 0, 4096, 0);
    wr(1'b1, 0, 0, 4096);
    start(8192, 0, 1, 1, 1'b1);
    finish_eval("t1");
    check("t1_ref_den_im", e_di, -4096);

    // 2: no roots
    start(1234, -77, 0, 0, 1'b1);
    finish_eval("t2");

    // 3: double zero
    wr(1'b0, 0, 0, -4096);
    wr(1'b0, 1, 0, -4096);
    start(0, 4096, 2, 0, 1'b1);
    finish_eval("t3");

    // 4: saturating difference, then a clean evaluation
    wr(1'b0, 0, -28672, 0);
    start(28672, 0, 1, 0, 1'b1);
    finish_eval("t4_sat");
    start(100, 50, 1, 0, 1'b1);
    finish_eval("t4_clean");

    // write in the accept cycle: evaluation uses old root, next one sees the new value
    start(300, -200, 1, 0, 1'b1);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 3'd0; cfg_re = 16'sd1000; cfg_im = -16'sd500;
    finish_eval("wr_accept_old");
    m_zr[0] = 1000; m_zi[0] = -500;
    start(300, -200, 1, 0, 1'b1);
    finish_eval("wr_accept_new");

    // 5: back-pressure in DONE
    bus.out_ready = 1'b0;
    start(2000, 1000, 1, 1, 1'b1);
    finish_eval("t5");
    bus.in_valid = 1'b1; bus.x_in = 16'sd512; bus.y_in = 16'sd256;
    for (int i = 0; i < 5; i++) begin
      cfg_we = (i % 2 == 0); cfg_sel = 1'b0; cfg_idx = 3'd0; cfg_re = 16'sd7; cfg_im = 16'sd7;
      tick();
      check("t5_hold_valid", bus.out_valid, 1);
      check("t5_hold_ready", bus.in_ready, 0);
      check("t5_hold_num_re", bus.num_re, e_nr);
      check("t5_hold_den_im", bus.den_im, e_di);
    end
    cfg_we = 1'b0;
    hz_re = e_nr; hz_im = e_ni;
    start(512, 256, 1, 1, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check("t5_single_handshake", bus.out_valid, 0);
    check("t5_ready_after", bus.in_ready, 1);
    finish_eval("t5_next");

    // 6: reset in the second EVAL cycle
    wr(1'b0, 0, 111, 222);
    wr(1'b0, 1, -333, 444);
    wr(1'b0, 2, 555, -666);
    start(1500, 700, 3, 0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_ready", bus.in_ready, 0);
    check("t6_rst_num_re", bus.num_re, 0);
    check("t6_rst_num_im", bus.num_im, 0);
    check("t6_rst_den_re", bus.den_re, 0);
    foreach (m_zr[i]) begin m_zr[i] = 0; m_zi[i] = 0; end
    foreach (m_pr[i]) begin m_pr[i] = 0; m_pi[i] = 0; end
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= bus.out_valid;
    end
    check("t6_no_valid", seen, 0);
    start(1500, 700, 1, 0, 1'b1);
    finish_eval("t6_cleared");
    check("t6_num_is_z", e_nr, 1500);

    // randomized roots, counts (including clamped ones) and samples
    for (int it = 0; it < 30; it++) begin
      bit wide;
      int nw, zr, zi;
      wide = ($urandom_range(3) == 0);
      nw = $urandom_range(3);
      for (int w = 0; w < nw; w++) begin
        if (wide) wr(1'($urandom_range(1)), $urandom_range(7),
                     int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
        else      wr(1'($urandom_range(1)), $urandom_range(7),
                     int'($urandom_range(8192)) - 4096, int'($urandom_range(8192)) - 4096);
      end
      zr = int'($urandom_range(8192)) - 4096;
      zi = int'($urandom_range(8192)) - 4096;
      start(zr, zi, $urandom_range(15), $urandom_range(15), 1'b1);
      finish_eval($sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rational_eval_seq.md
Name: rational_eval_seq

Overview:
- Sequential, parametrised evaluator of a complex rational function N(z)/D(z).
- N(z) = product over k of (z − zero_k); D(z) = product over k of (z − pole_k).
- Roots live in an internal register file loaded through a config port. Root counts are selected per evaluation.
- Uses one time-shared complex multiplier, a valid/ready input and output handshake, and separate numerator and denominator outputs for the downstream divider/colour-map stage.

Parameters:
- DATA_WIDTH, 16, width of each signed two's-complement real/imag component.
- FRAC_BITS, 12, fractional bits (Q3.12 at defaults). Must satisfy FRAC_BITS <= DATA_WIDTH−2 so that 1.0 is representable.
- MAX_ZEROS, 8, depth of the zero register file (>=1).
- MAX_POLES, 8, depth of the pole register file (>=1).
- ZW = $clog2(MAX_ZEROS+1), PW = $clog2(MAX_POLES+1), IW = $clog2(max(MAX_ZEROS,MAX_POLES)); these are derived, not overridable.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  root write strobe.
- cfg_sel  in  1  0 = zero file, 1 = pole file.
- cfg_idx  in  IW  root index.
- cfg_re, cfg_im  in  DATA_WIDTH each  root value.
- n_zeros  in  ZW  zeros used; sampled on input accept.
- n_poles  in  PW  poles used; sampled on input accept.
- in_valid  in  1  z sample valid.
- in_ready  out  1  block idle and able to accept.
- x_in, y_in  in  DATA_WIDTH each  Re(z), Im(z).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- num_re, num_im  out  DATA_WIDTH each  N(z).
- den_re, den_im  out  DATA_WIDTH each  D(z).
- out_ovf  out  1  a saturation occurred during this evaluation.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; all outputs = 0; in_ready = 0 while rst_n is low, 1 in the first cycle after release.
  - Root files clear to 0 and the sticky overflow clears.
- States:
  - IDLE: in_ready = 1.
  - EVAL: one multiply per cycle.
  - DONE: out_valid = 1, in_ready = 0.
- Accept (in_valid & in_ready in cycle A):
  - Latch z, nz = min(n_zeros, MAX_ZEROS) and np = min(n_poles, MAX_POLES).
  - Set acc_num = acc_den = 1.0 (1<<FRAC_BITS, imag 0) and clear ovf.
  - Go to EVAL, or to DONE if nz+np = 0.
- EVAL sequencing:
  - Cycles A+1 .. A+nz: acc_num <= acc_num × (z − zero[k]), k = 0..nz−1.
  - Cycles A+nz+1 .. A+nz+np: acc_den <= acc_den × (z − pole[k]), k = 0..np−1.
  - After the last multiply, go to DONE.
- Latency: out_valid is high in cycle A+nz+np+1; outputs are registered copies of the accumulators.
- DONE: outputs and out_valid are held stable while out_ready = 0. On out_valid & out_ready, return to IDLE; in_ready goes to 1 the next cycle. There is no overlap, so throughput is one result per nz+np+2 cycles.
- Arithmetic:
  - Difference: DATA_WIDTH+1-bit subtract, saturated to [−2^(DW−1), 2^(DW−1)−1].
  - Multiply: products are 2·DW bits; re = ac−bd and im = ad+bc are each 2·DW+1 bits.
  - Rounding: add 2^(FRAC_BITS−1), arithmetic shift right by FRAC_BITS, then saturate to DW.
  - Any saturation, in a difference or a product component, sets the sticky ovf, which is presented as out_ovf.
- Config:
  - cfg_we writes the selected file at cfg_idx on the clock edge, only when state = IDLE.
  - In IDLE a write in the same cycle as an accept is allowed, but the evaluation uses the pre-write values.
  - cfg_we in EVAL or DONE is silently dropped.
  - A cfg_idx >= the depth of the selected file is ignored.
- Counts above MAX are clamped, not wrapped. Zero counts yield 1.0 + 0i for that product.
- Reset mid-EVAL or mid-DONE aborts the evaluation; no out_valid is produced for the aborted sample.

Test Plan (defaults, 1.0 = 4096):
1. zero[0] = (4096, 0), pole[0] = (0, 4096), nz = np = 1, z = (8192, 0) → out_valid in cycle A+3; num = (4096, 0); den = (8192, −4096); out_ovf = 0.
2. nz = np = 0, z = (1234, −77) → out_valid in cycle A+1; num = den = (4096, 0).
3. zero[0] = zero[1] = (0, −4096), nz = 2, np = 0, z = (0, 4096) → num = (−16384, 0), den = (4096, 0), out_valid in cycle A+3.
4. zero[0] = (−28672, 0), nz = 1, z = (28672, 0) → difference saturates: num = (32767, 0), out_ovf = 1. The following clean evaluation returns out_ovf = 0.
5. Hold out_ready = 0 for 5 cycles in DONE with in_valid = 1 and cfg_we pulsed → outputs unchanged, in_ready = 0, root file unchanged. Releasing out_ready gives a single handshake, then the new sample is accepted.
6. Assert rst_n = 0 in the second EVAL cycle with nz = 3 → all outputs 0 immediately; no out_valid after release; the root file reads back as 0 via test 2-style evaluation with nz = 1 (num = z).
